// File: rtl/mux_nxparamb_pipe_sel.sv
// Registered N:1 word selector with valid/ready handshake and out-of-range error flag.
// Optional MUX_PIPE_SEL_SKID_EN adds a one-entry skid so sel_ready is a flop output.
`timescale 1ns / 1ps

module mux_nxparamb_pipe_sel #(
    parameter int unsigned WORD_WIDTH  = 12,
    parameter int unsigned NUM_ENTRIES = 40,
    parameter int unsigned SEL_WIDTH   = 6
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_ENTRIES*WORD_WIDTH-1:0] in,
    input  logic                              sel_valid,
    input  logic [SEL_WIDTH-1:0]              select,
    output logic                              sel_ready,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [WORD_WIDTH-1:0]             out,
    output logic                              out_err
);

    logic [WORD_WIDTH-1:0] w_sel_word;
    logic                  w_sel_err;
    logic                  w_out_free;
    logic                  w_accept;

    logic                  r_out_valid, w_nxt_out_valid;
    logic [WORD_WIDTH-1:0] r_out,       w_nxt_out;
    logic                  r_out_err,   w_nxt_out_err;

    // Explicit compare chain: out-of-range indices fall through to a zero word, never X.
    always_comb begin
        w_sel_word = '0;
        w_sel_err  = 1'b1;
        for (int k = 0; k < int'(NUM_ENTRIES); k++) begin
            if (select == SEL_WIDTH'(k)) begin
                w_sel_word = in[k*WORD_WIDTH +: WORD_WIDTH];
                w_sel_err  = 1'b0;
            end
        end
    end

    assign w_out_free = !r_out_valid || out_ready;

`ifdef MUX_PIPE_SEL_SKID_EN
    logic                  r_skid_valid, w_nxt_skid_valid;
    logic [WORD_WIDTH-1:0] r_skid,       w_nxt_skid;
    logic                  r_skid_err,   w_nxt_skid_err;

    assign sel_ready = !r_skid_valid;
    assign w_accept  = sel_valid && sel_ready;

    // A full skid implies sel_ready=0, so promotion and accept never coincide.
    always_comb begin
        w_nxt_out_valid  = r_out_valid;
        w_nxt_out        = r_out;
        w_nxt_out_err    = r_out_err;
        w_nxt_skid_valid = r_skid_valid;
        w_nxt_skid       = r_skid;
        w_nxt_skid_err   = r_skid_err;
        if (w_out_free) begin
            if (r_skid_valid) begin
                w_nxt_out_valid  = 1'b1;
                w_nxt_out        = r_skid;
                w_nxt_out_err    = r_skid_err;
                w_nxt_skid_valid = 1'b0;
            end else if (w_accept) begin
                w_nxt_out_valid = 1'b1;
                w_nxt_out       = w_sel_word;
                w_nxt_out_err   = w_sel_err;
            end else begin
                w_nxt_out_valid = 1'b0;
            end
        end else if (w_accept) begin
            w_nxt_skid_valid = 1'b1;
            w_nxt_skid       = w_sel_word;
            w_nxt_skid_err   = w_sel_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_skid_valid <= 1'b0;
            r_skid       <= '0;
            r_skid_err   <= 1'b0;
        end else begin
            r_skid_valid <= w_nxt_skid_valid;
            r_skid       <= w_nxt_skid;
            r_skid_err   <= w_nxt_skid_err;
        end
    end
`else
    assign sel_ready = w_out_free;
    assign w_accept  = sel_valid && sel_ready;

    always_comb begin
        w_nxt_out_valid = r_out_valid;
        w_nxt_out       = r_out;
        w_nxt_out_err   = r_out_err;
        if (w_accept) begin
            w_nxt_out_valid = 1'b1;
            w_nxt_out       = w_sel_word;
            w_nxt_out_err   = w_sel_err;
        end else if (out_ready) begin
            w_nxt_out_valid = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_out_err   <= 1'b0;
        end else begin
            r_out_valid <= w_nxt_out_valid;
            r_out       <= w_nxt_out;
            r_out_err   <= w_nxt_out_err;
        end
    end

    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign out_err   = r_out_err;

endmodule

// File: tb/tb_mux_nxparamb_pipe_sel.sv
// Self-checking bench for mux_nxparamb_pipe_sel: directed table, stall, scoreboard,
// async reset and parameter-sweep checks; adapts to MUX_PIPE_SEL_SKID_EN.
`timescale 1ns / 1ps

module tb_mux_nxparamb_pipe_sel;

    localparam int W = 12;
    localparam int N = 40;
    localparam int S = 6;
    localparam int WB = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [N*W-1:0] in_bus;
    logic           sel_valid;
    logic [S-1:0]   select;
    logic           sel_ready;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_word;
    logic           out_err;

    logic [2*WB-1:0]  in2;
    logic             sv2, sr2, ov2, ordy2, e2;
    logic [0:0]       sel2;
    logic [WB-1:0]    o2;
    logic [64*WB-1:0] in64;
    logic             sv64, sr64, ov64, ordy64, e64;
    logic [5:0]       sel64;
    logic [WB-1:0]    o64;

    mux_nxparamb_pipe_sel #(.WORD_WIDTH(W), .NUM_ENTRIES(N), .SEL_WIDTH(S)) u_dut (
        .clk(clk), .rst(rst), .in(in_bus), .sel_valid(sel_valid), .select(select),
        .sel_ready(sel_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out(out_word), .out_err(out_err)
    );

    mux_nxparamb_pipe_sel #(.WORD_WIDTH(WB), .NUM_ENTRIES(2), .SEL_WIDTH(1)) u_dut2 (
        .clk(clk), .rst(rst), .in(in2), .sel_valid(sv2), .select(sel2),
        .sel_ready(sr2), .out_valid(ov2), .out_ready(ordy2), .out(o2), .out_err(e2)
    );

    mux_nxparamb_pipe_sel #(.WORD_WIDTH(WB), .NUM_ENTRIES(64), .SEL_WIDTH(6)) u_dut64 (
        .clk(clk), .rst(rst), .in(in64), .sel_valid(sv64), .select(sel64),
        .sel_ready(sr64), .out_valid(ov64), .out_ready(ordy64), .out(o64), .out_err(e64)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WB-1:0] went(input int k);
        return 32'(k) * 32'h0101_0101 + 32'h1234_0000;
    endfunction

    function automatic logic [W-1:0] rent(input int seed, input int k);
        return W'(seed * 13 + k * 5 + 7);
    endfunction

    task automatic fill_default();
        for (int k = 0; k < N; k++) in_bus[k*W +: W] = W'(12'h100 + k);
    endtask

    task automatic fill_seed(input int seed);
        for (int k = 0; k < N; k++) in_bus[k*W +: W] = rent(seed, k);
    endtask

    typedef struct {
        logic [S-1:0] sel;
        logic [W-1:0] exp_out;
        logic         exp_err;
    } vec_t;

    typedef struct {
        logic [W-1:0] w;
        logic         e;
    } exp_t;

    vec_t vecs[6];
    exp_t q[$];

    initial begin
        int   n_acc, acc, ret, cyc;
        exp_t ex;

        vecs[0] = '{sel: 6'd0,  exp_out: 12'h100, exp_err: 1'b0};
        vecs[1] = '{sel: 6'd5,  exp_out: 12'h105, exp_err: 1'b0};
        vecs[2] = '{sel: 6'd39, exp_out: 12'h127, exp_err: 1'b0};
        vecs[3] = '{sel: 6'd40, exp_out: 12'h000, exp_err: 1'b1};
        vecs[4] = '{sel: 6'd63, exp_out: 12'h000, exp_err: 1'b1};
        vecs[5] = '{sel: 6'd12, exp_out: 12'h10C, exp_err: 1'b0};

        rst = 1'b1; sel_valid = 1'b0; select = '0; out_ready = 1'b1;
        sv2 = 1'b0; sel2 = '0; ordy2 = 1'b1; sv64 = 1'b0; sel64 = '0; ordy64 = 1'b1;
        fill_default();
        for (int k = 0; k < 2; k++) in2[k*WB +: WB] = went(k);
        for (int k = 0; k < 64; k++) in64[k*WB +: WB] = went(k);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_out", out_word, 0);
        check("reset_out_err", out_err, 0);
        check("reset_sel_ready", sel_ready, 1);
        step();
        step();
        rst = 1'b0;
        step();

        // Table: back-to-back selects, 1-cycle latency, no idle cycles.
        for (int i = 0; i < 6; i++) begin
            sel_valid = 1'b1; select = vecs[i].sel; out_ready = 1'b1;
            #1;
            check("tbl_sel_ready", sel_ready, 1);
            step();
            check("tbl_out", out_word, vecs[i].exp_out);
            check("tbl_err", out_err, vecs[i].exp_err);
            check("tbl_valid", out_valid, 1);
        end

        // Backpressure: hold 12'h107 for 4 stalled cycles while inputs change.
        select = 6'd7;
        step();
        check("bp_first", out_word, 12'h107);
        out_ready = 1'b0; select = 6'd3; n_acc = 0;
        for (int i = 0; i < 4; i++) begin
            in_bus[3*W +: W] = W'(12'h5A0 + i);
            in_bus[7*W +: W] = W'(12'hE00 + i);
            #1;
            if (sel_valid && sel_ready) n_acc++;
            @(posedge clk);
            #1;
            check("bp_out", out_word, 12'h107);
            check("bp_valid", out_valid, 1);
`ifndef MUX_PIPE_SEL_SKID_EN
            check("bp_ready_low", sel_ready, 0);
`endif
        end
`ifdef MUX_PIPE_SEL_SKID_EN
        check("bp_accepts", n_acc, 1);
        check("bp_ready_low", sel_ready, 0);
        out_ready = 1'b1; sel_valid = 1'b0;
        step();
        check("bp_skid_out", out_word, 12'h5A0);
        check("bp_skid_valid", out_valid, 1);
        step();
        check("bp_drain_valid", out_valid, 0);
`else
        check("bp_accepts", n_acc, 0);
        out_ready = 1'b1; sel_valid = 1'b0;
        step();
        check("bp_drain_valid", out_valid, 0);
        check("bp_hold_last", out_word, 12'h107);
`endif

        // Scoreboard: 100 random selects, random backpressure, changing inputs.
        acc = 0; ret = 0; cyc = 0;
        while ((acc < 100 || q.size() > 0 || out_valid) && cyc < 2000) begin
            fill_seed(cyc);
            sel_valid = (acc < 100) ? ($urandom_range(0, 3) != 0) : 1'b0;
            select    = S'($urandom_range(0, 63));
            out_ready = (acc >= 100) ? 1'b1 : ($urandom_range(0, 2) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("sb_spurious", 1, 0);
                end else begin
                    ex = q.pop_front();
                    check("sb_out", out_word, ex.w);
                    check("sb_err", out_err, ex.e);
                end
                ret++;
            end
            if (sel_valid && sel_ready) begin
                ex.e = (int'(select) >= N);
                ex.w = ex.e ? '0 : rent(cyc, int'(select));
                q.push_back(ex);
                acc++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        check("sb_no_timeout", (cyc < 2000), 1);
        check("sb_count", ret, 100);

        // Async reset while stalled, with a second request pending.
        fill_default();
        sel_valid = 1'b1; select = 6'd9; out_ready = 1'b1;
        step();
        check("rs_pre_out", out_word, 12'h109);
        out_ready = 1'b0; select = 6'd10;
        step();
        sel_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rs_async_valid", out_valid, 0);
        check("rs_async_out", out_word, 0);
        check("rs_async_err", out_err, 0);
        #1;
        rst = 1'b0;
        #1;
        check("rs_sel_ready", sel_ready, 1);
        out_ready = 1'b1;
        step();
        check("rs_no_stale1", out_valid, 0);
        step();
        check("rs_no_stale2", out_valid, 0);

        // Parameter sweep: 2-entry and full 64-entry instances.
        check("sw_ready2", sr2, 1);
        check("sw_ready64", sr64, 1);
        for (int i = 0; i < 64; i++) begin
            sv2 = 1'b1; sv64 = 1'b1;
            sel2 = 1'(i % 2); sel64 = 6'(i);
            step();
            check("sw64_out", o64, went(i));
            check("sw64_err", e64, 0);
            check("sw64_valid", ov64, 1);
            check("sw2_out", o2, went(i % 2));
            check("sw2_err", e2, 0);
            check("sw2_valid", ov2, 1);
        end
        sv2 = 1'b0; sv64 = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mux_nxparamb_pipe_sel.md
Name: mux_nxparamb_pipe_sel

Overview:
Parametrised, registered N:1 word selector for the issue stage; next generation of the combinational 40-entry word mux.
- Generalised in word width and entry count.
- Adds a valid/ready handshake, a registered output stage and out-of-range select detection. Out-of-range select returns a defined zero word plus an error flag instead of X.
- Used where selected wavefront fields (PC, base, tag) must be timing-isolated from downstream arbitration logic.

Parameters:
WORD_WIDTH, 12, width of each input word and of out.
NUM_ENTRIES, 40, number of words packed in in; legal range 2..64.
SEL_WIDTH, 6, width of select; must satisfy 2**SEL_WIDTH >= NUM_ENTRIES.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
in  input  NUM_ENTRIES*WORD_WIDTH  packed words; entry k occupies in[(k+1)*WORD_WIDTH-1 : k*WORD_WIDTH].
sel_valid  input  1  select request valid.
select  input  SEL_WIDTH  entry index.
sel_ready  output  1  block accepts a request this cycle.
out_valid  output  1  out/out_err hold a result.
out_ready  input  1  consumer accepts the result this cycle.
out  output  WORD_WIDTH  selected word.
out_err  output  1  request's select was >= NUM_ENTRIES.

Behaviour:
- Reset (async assert; deassert synchronous to clk): out_valid=0, out=0, out_err=0. Any held result is discarded.
- Accept: sel_valid && sel_ready at a rising edge. in and select are sampled that cycle; the source may change in afterwards.
- Latency: exactly 1 cycle. The result is visible with out_valid=1 in the cycle after acceptance.
- Select decode:
  - select < NUM_ENTRIES: out = entry[select], out_err = 0.
  - select >= NUM_ENTRIES: out = 0, out_err = 1. Never X.
- Output handshake: result retires on out_valid && out_ready. While out_valid=1 && out_ready=0, out/out_err/out_valid hold stable.
- Base ready (no macro): sel_ready = !out_valid || out_ready. This is combinational from out_ready.
- Simultaneous retire and accept in the same cycle: the new result replaces the old one; out_valid stays 1. Full throughput is 1 result/cycle.
- No accept and a retire: out_valid drops to 0 next cycle. out keeps its last value; it is don't-care to consumers but must not go X.
- sel_valid=0: no state change except a retire.
- Reset mid-stall: the held result is dropped. sel_ready=1 after reset.

Optional Feature:
MUX_PIPE_SEL_SKID_EN
- Defined: adds a one-entry skid register so that sel_ready is a flop output (sel_ready = skid empty). There is no combinational path out_ready -> sel_ready.
- A request accepted while the output is stalled goes to the skid. The skid promotes to the output on the next retire. Order is preserved.
- Capacity is 2 results. Throughput stays 1/cycle. Latency is 1 cycle when the output stage is free, otherwise 1 + stall cycles.
- Reset clears the skid.
- Undefined: behaviour exactly as Behaviour above, with no skid storage.

Test Plan:
- Basic select, WORD_WIDTH=12, NUM_ENTRIES=40, entry k = 12'h100+k, out_ready=1: select=0, 5, 39 in three consecutive cycles. Required: out = 12'h100, 12'h105, 12'h127 on cycles 1, 2, 3; out_err=0; out_valid continuous.
- Out of range: select=40, then select=63. Required: out=0, out_err=1 for each; the next in-range select returns out_err=0.
- Backpressure: accept select=7 (entry 12'h107), hold out_ready=0 for 4 cycles while changing in and presenting sel_valid. Required: out stays 12'h107, out_valid=1 throughout.
  - Base: sel_ready=0 for the whole stall.
  - Skid build: exactly one extra request is accepted, then sel_ready=0.
- Back-to-back with simultaneous retire/accept, 100 random selects, random out_ready: scoreboard requires in-order, lossless, duplicate-free results. Base build shows zero idle cycles when out_ready=1.
- Reset mid-stall: out_valid=1, out_ready=0, assert rst asynchronously between edges. Required:
  - out_valid/out/out_err go to 0 immediately, without waiting for a clock edge.
  - After deassert, sel_ready=1 and no stale result appears.
- Parameter sweep: NUM_ENTRIES=2/SEL_WIDTH=1 and NUM_ENTRIES=64/SEL_WIDTH=6, WORD_WIDTH=32. Required: every index returns its entry; out_err never asserts when NUM_ENTRIES = 2**SEL_WIDTH.
